// File: rtl/gen_frame_collector_pkg.sv
// Shared defaults and types for the frame collector: sample/pixel geometry
// and the read-side state encoding.
package gen_frame_collector_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FRAC_BITS  = 8;
   localparam int DEF_IMG_W      = 23;
   localparam int DEF_PIX_WIDTH  = 8;
   localparam int DEF_FRAME_PIX  = DEF_IMG_W * DEF_IMG_W;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RUN  = 1'b1
   } rd_state_e;

endpackage

// File: rtl/gen_frame_collector_if.sv
// Outgoing pixel stream: valid/ready handshake with frame/row markers.
interface gen_frame_collector_if
   import gen_frame_collector_pkg::*;
#(
   parameter int PIX_WIDTH = DEF_PIX_WIDTH
) ();

   logic                 m_valid;
   logic                 m_ready;
   logic [PIX_WIDTH-1:0] m_data;
   logic                 m_sof;
   logic                 m_eol;
   logic                 m_eof;

   modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
   modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);

endinterface

// File: rtl/gen_frame_ram.sv
// Two-bank frame store: one write port, one registered read port.
// Address is {bank, index}; bank 1 is placed directly after bank 0.
module gen_frame_ram
   import gen_frame_collector_pkg::*;
#(
   parameter int PIX_WIDTH = DEF_PIX_WIDTH,
   parameter int FRAME_PIX = DEF_FRAME_PIX,
   parameter int IDX_W     = $clog2(FRAME_PIX)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [IDX_W:0]       waddr,
   input  logic [PIX_WIDTH-1:0] wdata,
   input  logic                 re,
   input  logic [IDX_W:0]       raddr,
   output logic [PIX_WIDTH-1:0] rdata
);

   localparam int DEPTH = 2 * FRAME_PIX;
   localparam int ROW_W = $clog2(DEPTH);

   logic [PIX_WIDTH-1:0] mem [DEPTH];

   function automatic logic [ROW_W-1:0] row(input logic [IDX_W:0] a);
      return a[IDX_W] ? ROW_W'(FRAME_PIX) + ROW_W'(a[IDX_W-1:0])
                      : ROW_W'(a[IDX_W-1:0]);
   endfunction

   // Array write and one-cycle-latency read; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (we)
         mem[row(waddr)] <= wdata;
      if (re)
         rdata <= mem[row(raddr)];
   end

endmodule

// File: rtl/gen_frame_collector.sv
// Captures the generator's free-running sample stream into ping-pong banks
// (quantised to 8-bit pixels), then replays each complete frame on a
// valid/ready stream with sof/eol/eof. Frames with no free bank are dropped.
module gen_frame_collector
   import gen_frame_collector_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int PIX_WIDTH  = DEF_PIX_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   gen_frame_collector_if.master m,
   output logic                  frame_drop,
   output logic [15:0]           drop_count,
   output logic                  busy
);

   localparam int FRAME_PIX = IMG_W * IMG_W;
   localparam int IDX_W     = $clog2(FRAME_PIX);
   localparam int COL_W     = $clog2(IMG_W);
   localparam int SHIFT     = FRAC_BITS - 7;
   localparam int ENTRY_W   = PIX_WIDTH + 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIX - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

   logic signed [DATA_WIDTH:0] q_shifted, q_biased;
   logic [PIX_WIDTH-1:0]       q_pix;

   logic [IDX_W-1:0] wr_cnt;
   logic             wr_bank, wr_accept, wr_first, wr_take, wr_en, full_set;
   logic [1:0]       full;

   rd_state_e        rd_state, rd_next;
   logic             rd_bank, rd_issue, rd_last, full_clr;
   logic [IDX_W-1:0] rd_cnt;
   logic [COL_W-1:0] rd_col;
   logic             rd_pend, pend_sof, pend_eol, pend_eof;
   logic [PIX_WIDTH-1:0] ram_rdata;

   logic [ENTRY_W-1:0] buf_mem [2];
   logic               buf_wr, buf_rd, pop, out_valid;
   logic [1:0]         buf_cnt;
   logic [2:0]         level;
   logic [ENTRY_W-1:0] head;

   // Quantiser: drop to 7 fractional bits, re-bias around mid-scale, clamp.
   always_comb begin
      q_shifted = $signed({data_in[DATA_WIDTH-1], data_in}) >>> SHIFT;
      q_biased  = q_shifted + $signed((DATA_WIDTH+1)'(2**(PIX_WIDTH-1)));
      if (q_biased < 0)
         q_pix = '0;
      else if (q_biased > $signed((DATA_WIDTH+1)'(2**PIX_WIDTH - 1)))
         q_pix = '1;
      else
         q_pix = q_biased[PIX_WIDTH-1:0];
   end

   // Accept decision on pixel 0, then remembered for the rest of the frame.
   always_comb begin
      wr_first = valid_in && (wr_cnt == '0);
      wr_take  = wr_first ? !full[wr_bank] : wr_accept;
      wr_en    = valid_in && wr_take && !clear;
      full_set = wr_en && (wr_cnt == LAST_IDX);
   end

   // Write counter, bank selection and drop accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt     <= '0;
         wr_bank    <= 1'b0;
         wr_accept  <= 1'b0;
         frame_drop <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         wr_cnt     <= '0;
         wr_bank    <= 1'b0;
         wr_accept  <= 1'b0;
         frame_drop <= 1'b0;
         drop_count <= '0;
      end else begin
         frame_drop <= wr_first && full[wr_bank];
         if (wr_first && full[wr_bank] && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
         if (valid_in) begin
            wr_cnt <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + IDX_W'(1);
            if (wr_first)
               wr_accept <= !full[wr_bank];
         end
         if (full_set)
            wr_bank <= ~wr_bank;
      end
   end

   // Bank-full flags; the writer and reader always touch different banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         full <= '0;
      else if (clear)
         full <= '0;
      else begin
         for (int b = 0; b < 2; b++) begin
            if (full_set && wr_bank == 1'(b))
               full[b] <= 1'b1;
            else if (full_clr && rd_bank == 1'(b))
               full[b] <= 1'b0;
         end
      end
   end

   // Read FSM: issue a read whenever the output side has room, counting
   // the pixel being popped this cycle so a steady 1 pixel/cycle is kept.
   always_comb begin
      rd_next  = rd_state;
      rd_issue = 1'b0;
      pop      = out_valid && m.m_ready;
      level    = 3'(buf_cnt) + 3'(rd_pend) - 3'(pop);
      rd_last  = (rd_cnt == LAST_IDX);
      case (rd_state)
         RD_IDLE: begin
            if (full[rd_bank] && level < 3'd2) begin
               rd_issue = 1'b1;
               rd_next  = RD_RUN;
            end
         end
         RD_RUN: begin
            if (level < 3'd2) begin
               rd_issue = 1'b1;
               if (rd_last)
                  rd_next = RD_IDLE;
            end
         end
         default: rd_next = RD_IDLE;
      endcase
      full_clr = rd_issue && rd_last;
   end

   // Read counters and the marker pipeline that tracks the RAM latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         rd_bank  <= 1'b0;
         rd_cnt   <= '0;
         rd_col   <= '0;
         rd_pend  <= 1'b0;
         pend_sof <= 1'b0;
         pend_eol <= 1'b0;
         pend_eof <= 1'b0;
      end else if (clear) begin
         rd_state <= RD_IDLE;
         rd_bank  <= 1'b0;
         rd_cnt   <= '0;
         rd_col   <= '0;
         rd_pend  <= 1'b0;
         pend_sof <= 1'b0;
         pend_eol <= 1'b0;
         pend_eof <= 1'b0;
      end else begin
         rd_state <= rd_next;
         rd_pend  <= rd_issue;
         pend_sof <= (rd_cnt == '0);
         pend_eol <= (rd_col == LAST_COL);
         pend_eof <= rd_last;
         if (rd_issue) begin
            rd_cnt <= rd_last ? '0 : rd_cnt + IDX_W'(1);
            rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + COL_W'(1);
            if (rd_last)
               rd_bank <= ~rd_bank;
         end
      end
   end

   // Two-entry output buffer; pixel and markers travel together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         buf_wr     <= 1'b0;
         buf_rd     <= 1'b0;
         buf_cnt    <= '0;
      end else if (clear) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         buf_wr     <= 1'b0;
         buf_rd     <= 1'b0;
         buf_cnt    <= '0;
      end else begin
         if (rd_pend) begin
            buf_mem[buf_wr] <= {ram_rdata, pend_sof, pend_eol, pend_eof};
            buf_wr          <= ~buf_wr;
         end
         if (pop)
            buf_rd <= ~buf_rd;
         buf_cnt <= buf_cnt + 2'(rd_pend) - 2'(pop);
      end
   end

   assign head      = buf_mem[buf_rd];
   assign out_valid = (buf_cnt != 2'd0);
   assign m.m_valid = out_valid;
   assign m.m_data  = out_valid ? head[ENTRY_W-1:3] : '0;
   assign m.m_sof   = out_valid && head[2];
   assign m.m_eol   = out_valid && head[1];
   assign m.m_eof   = out_valid && head[0];
   assign busy      = (|full) || (rd_state == RD_RUN) || rd_pend || out_valid;

   gen_frame_ram #(
      .PIX_WIDTH (PIX_WIDTH),
      .FRAME_PIX (FRAME_PIX),
      .IDX_W     (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wr_bank, wr_cnt}),
      .wdata (q_pix),
      .re    (rd_issue),
      .raddr ({rd_bank, rd_cnt}),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_gen_frame_collector.sv
// Directed bench for gen_frame_collector: ramp, saturation, backpressure,
// overflow drop, bank recycle, reset and clear mid-frame.
module tb_gen_frame_collector;

   localparam int N     = 529;
   localparam int IMG_W = 23;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        valid_in = 1'b0;
   logic [15:0] data_in = '0;
   logic        frame_drop, busy;
   logic [15:0] drop_count;
   logic [10:0] cur;

   int          checks = 0;
   int          fails = 0;
   int          got_idx = 0;
   int          stall_errs = 0;
   int          drop_pulses = 0;
   bit          rand_ready = 0;
   logic [10:0] got_q[$];
   logic [10:0] exp_q[$];
   logic        stall_prev = 1'b0;
   logic [10:0] stall_val = '0;

   gen_frame_collector_if bus ();

   gen_frame_collector dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .m          (bus),
      .frame_drop (frame_drop),
      .drop_count (drop_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign cur = {bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof};

   // Records accepted pixels and flags any change of a stalled pixel.
   always @(negedge clk) begin
      if (!rst_n || clear) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && (bus.m_valid !== 1'b1 || cur !== stall_val))
            stall_errs++;
         if (bus.m_valid && bus.m_ready)
            got_q.push_back(cur);
         stall_prev = bus.m_valid && !bus.m_ready;
         stall_val  = cur;
      end
   end

   // Absolute time limit in case a wait is ever unbounded.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [15:0] gen_sample(input int mode, input int base, input int k);
      logic [15:0] tab [5];
      tab = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFF00, 16'h0000};
      case (mode)
         0:       return 16'(k * 2);
         1:       return 16'((((base + k) % 256) - 128) * 2);
         default: return (k < 5) ? tab[k] : 16'h0000;
      endcase
   endfunction

   function automatic logic [7:0] gen_pix(input int mode, input int base, input int k);
      logic [7:0] tab [5];
      int v;
      tab = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
      case (mode)
         0: begin
            v = k + 128;
            if (v > 255) v = 255;
            return 8'(v);
         end
         1:       return 8'((base + k) % 256);
         default: return (k < 5) ? tab[k] : 8'd128;
      endcase
   endfunction

   function automatic logic [10:0] exp_entry(input int mode, input int base, input int k);
      return {gen_pix(mode, base, k), k == 0, (k % IMG_W) == IMG_W - 1, k == N - 1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready)
         bus.m_ready = 1'($urandom_range(0, 1));
      if (frame_drop)
         drop_pulses++;
   endtask

   task automatic send_frame(input int mode, input int base, input int count, input bit kept);
      for (int k = 0; k < count; k++) begin
         valid_in = 1'b1;
         data_in  = gen_sample(mode, base, k);
         if (kept)
            exp_q.push_back(exp_entry(mode, base, k));
         step();
      end
      valid_in = 1'b0;
      data_in  = '0;
   endtask

   task automatic wait_pixels(input int n, output bit timed_out);
      int budget = 0;
      while (got_q.size() < got_idx + n && budget < 6000) begin
         step();
         budget++;
      end
      timed_out = (got_q.size() < got_idx + n);
      repeat (8) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.m_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== 8'd0 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: valid=%b data=%0d busy=%b, want 0 0 0", bus.m_valid, bus.m_data, busy);
      end
      checks++;
      if (drop_count !== 16'd0 || frame_drop !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_drop: count=%0d pulse=%b, want 0 0", drop_count, frame_drop);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_sof !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_release: valid=%b sof=%b, want 0 0", bus.m_valid, bus.m_sof);
      end
   endtask

   task automatic test_ramp();
      bit to;
      bus.m_ready = 1'b1;
      send_frame(0, 0, N, 1'b1);
      checks++;
      if (bus.m_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL ramp_latency_t0: valid=%b, want 0", bus.m_valid);
      end
      step();
      checks++;
      if (bus.m_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL ramp_latency_t1: valid=%b, want 0", bus.m_valid);
      end
      step();
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd128 || bus.m_sof !== 1'b1) begin
         fails++;
         $display("[TB] FAIL ramp_latency_t2: valid=%b data=%0d sof=%b, want 1 128 1", bus.m_valid, bus.m_data, bus.m_sof);
      end
      wait_pixels(exp_q.size(), to);
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL ramp_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL ramp_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic test_saturation();
      bit to;
      bus.m_ready = 1'b1;
      send_frame(2, 0, N, 1'b1);
      wait_pixels(exp_q.size(), to);
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL sat_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL sat_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      bit to;
      rand_ready = 1;
      send_frame(1, 10, N, 1'b1);
      send_frame(1, 77, N, 1'b1);
      wait_pixels(exp_q.size(), to);
      rand_ready = 0;
      bus.m_ready = 1'b1;
      step();
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL bp_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL bp_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      checks++;
      if (stall_errs !== 0) begin
         fails++;
         $display("[TB] FAIL bp_stall_stable: %0d changes during stall, want 0", stall_errs);
      end
      checks++;
      if (drop_count !== 16'd0) begin
         fails++;
         $display("[TB] FAIL bp_no_drop: drop_count=%0d, want 0", drop_count);
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic test_overflow();
      bit to;
      bus.m_ready = 1'b0;
      drop_pulses = 0;
      send_frame(1, 3, N, 1'b1);
      send_frame(1, 150, N, 1'b1);
      send_frame(1, 200, N, 1'b0);
      repeat (4) step();
      checks++;
      if (drop_pulses !== 1) begin
         fails++;
         $display("[TB] FAIL ovf_pulses: saw %0d frame_drop pulses, want 1", drop_pulses);
      end
      checks++;
      if (drop_count !== 16'd1) begin
         fails++;
         $display("[TB] FAIL ovf_count: drop_count=%0d, want 1", drop_count);
      end
      checks++;
      if (busy !== 1'b1 || got_q.size() !== got_idx) begin
         fails++;
         $display("[TB] FAIL ovf_hold: busy=%b pixels=%0d, want 1 0", busy, got_q.size() - got_idx);
      end
      bus.m_ready = 1'b1;
      wait_pixels(exp_q.size(), to);
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL ovf_drain_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL ovf_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic test_recycle();
      bit to;
      int budget;
      bus.m_ready = 1'b0;
      drop_pulses = 0;
      send_frame(1, 40, N, 1'b1);
      send_frame(1, 90, N, 1'b1);
      bus.m_ready = 1'b1;
      budget = 0;
      while (!(bus.m_valid && bus.m_eof) && budget < 2000) begin
         step();
         budget++;
      end
      checks++;
      if (budget >= 2000) begin
         fails++;
         $display("[TB] FAIL recycle_eof_wait: no eof within %0d cycles", budget);
      end
      send_frame(1, 220, N, 1'b1);
      checks++;
      if (drop_pulses !== 0 || drop_count !== 16'd1) begin
         fails++;
         $display("[TB] FAIL recycle_accept: pulses=%0d drop_count=%0d, want 0 1", drop_pulses, drop_count);
      end
      wait_pixels(exp_q.size(), to);
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL recycle_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL recycle_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      bus.m_ready = 1'b1;
      send_frame(1, 5, 200, 1'b0);
      rst_n = 1'b0;
      step();
      checks++;
      if (bus.m_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd0) begin
         fails++;
         $display("[TB] FAIL rst_mid_state: valid=%b busy=%b drop=%0d, want 0 0 0", bus.m_valid, busy, drop_count);
      end
      step();
      rst_n = 1'b1;
      step();
      send_frame(1, 61, N, 1'b1);
      wait_pixels(exp_q.size(), to);
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL rst_mid_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL rst_mid_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic test_clear();
      bit to;
      bus.m_ready = 1'b1;
      send_frame(1, 17, 300, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL clear_state: valid=%b busy=%b, want 0 0", bus.m_valid, busy);
      end
      send_frame(1, 123, N, 1'b1);
      wait_pixels(exp_q.size(), to);
      checks++;
      if (got_q.size() - got_idx !== exp_q.size()) begin
         fails++;
         $display("[TB] FAIL clear_count: got %0d pixels, want %0d", got_q.size() - got_idx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && got_idx + i < got_q.size(); i++) begin
         checks++;
         if (got_q[got_idx + i] !== exp_q[i]) begin
            fails++;
            $display("[TB] FAIL clear_pixel[%0d]: got %h, want %h", i, got_q[got_idx + i], exp_q[i]);
         end
      end
      got_idx = got_q.size();
      exp_q.delete();
   endtask

   // Runs every scenario in order, then reports.
   initial begin
      bus.m_ready = 1'b0;
      test_reset();
      test_ramp();
      test_saturation();
      test_backpressure();
      test_overflow();
      test_recycle();
      test_reset_mid_frame();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
